// File: rtl/axi_setting_reg_wide_pkg.sv
// Shared constants and helpers for the wide settings-register stream bridge.
package axi_setting_reg_wide_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  // Saturating increment for the dropped-commit counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/setting_beat_fifo.sv
// Small register FIFO holding committed beats behind the output register.
// Depth need not be a power of two; pointers wrap explicitly.
module setting_beat_fifo #(
  parameter int DW    = 65,
  parameter int DEPTH = 3,
  parameter int PTRW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int CW = PTRW + 1;

  logic [DW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wptr;
  logic [PTRW-1:0] rptr;
  logic [CW-1:0]   count;

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_next(wptr);
      if (pop)  rptr <= ptr_next(rptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/axi_setting_reg_wide.sv
// Settings-bus to AXI-stream bridge: stages 32-bit words into a wide beat and
// queues committed beats (FIFO plus output register) toward a throttling sink.
module axi_setting_reg_wide
  import axi_setting_reg_wide_pkg::*;
#(
  parameter int ADDR           = 0,
  parameter int AWIDTH         = 8,
  parameter int NWORDS         = 2,
  parameter int WIDTH          = 64,
  parameter int MSB_ALIGN      = 0,
  parameter int USE_ADDR_LAST  = 0,
  parameter int ADDR_LAST      = ADDR + NWORDS,
  parameter int STROBE_LAST    = 0,
  parameter int FIFO_SIZE      = 2,
  parameter int REPEATS        = 0,
  parameter logic [NWORDS*WORD_W-1:0] DATA_AT_RESET = '0,
  parameter bit VALID_AT_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [AWIDTH-1:0] set_addr,
  input  logic [31:0]       set_data,
  output logic [WIDTH-1:0]  o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [FIFO_SIZE:0] occupied,
  output logic              error_stb,
  output logic [15:0]       overflow_cnt
);

  localparam int CAP   = 1 << FIFO_SIZE;
  localparam int BEATW = NWORDS * WORD_W;
  localparam int PTRW  = (FIFO_SIZE > 0) ? FIFO_SIZE : 1;
  localparam int OW    = FIFO_SIZE + 1;
  localparam logic [OW-1:0]     CAP_O  = OW'(CAP);
  localparam logic [AWIDTH-1:0] A_TOP  = AWIDTH'(ADDR + NWORDS - 1);
  localparam logic [AWIDTH-1:0] A_LAST = AWIDTH'(ADDR_LAST);

  logic [BEATW-1:0] staging;
  logic [BEATW-1:0] commit_beat;
  logic             commit_word;
  logic             commit_last;
  logic             commit;
  logic             beat_last;

  logic [BEATW-1:0] out_beat;
  logic             out_last;
  logic             out_valid;
  logic             out_rpt;
  logic [OW-1:0]    occ;

  logic             hs;
  logic             dec;
  logic             accept;
  logic             drop;
  logic             load;
  logic             take_fifo;
  logic             take_commit;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BEATW:0]   fifo_dout;

  always_comb begin
    commit_word = set_stb && (set_addr == A_TOP);
    commit_last = set_stb && (USE_ADDR_LAST != 0) && (set_addr == A_LAST);
    commit      = commit_word || commit_last;
    beat_last   = (STROBE_LAST != 0) || commit_last;
    commit_beat = staging;
    commit_beat[BEATW-1 -: WORD_W] = set_data;
  end

  // A repeat beat is not counted, so it may be overwritten at any time.
  always_comb begin
    hs          = out_valid && o_tready;
    dec         = hs && !out_rpt;
    accept      = commit && !clear && ((occ < CAP_O) || ((occ == CAP_O) && hs));
    drop        = commit && !clear && !accept;
    load        = !out_valid || out_rpt || hs;
    take_fifo   = load && !fifo_empty;
    take_commit = load && fifo_empty && accept;
    fifo_pop    = take_fifo && !clear;
    fifo_push   = accept && !take_commit && (!fifo_full || fifo_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= DATA_AT_RESET;
    end else begin
      for (int i = 0; i < NWORDS; i++) begin
        if (set_stb && (set_addr == AWIDTH'(ADDR + i)))
          staging[i*WORD_W +: WORD_W] <= set_data;
      end
      if (commit_last) staging[BEATW-1 -: WORD_W] <= set_data;
    end
  end

  generate
    if (FIFO_SIZE > 0) begin : g_fifo
      setting_beat_fifo #(
        .DW    (BEATW + 1),
        .DEPTH (CAP - 1),
        .PTRW  (PTRW)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (fifo_push),
        .din   ({beat_last, commit_beat}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
      );
    end else begin : g_nofifo
      assign fifo_dout  = '0;
      assign fifo_full  = 1'b1;
      assign fifo_empty = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_beat  <= DATA_AT_RESET;
      out_last  <= 1'b0;
      out_valid <= VALID_AT_RESET;
      out_rpt   <= 1'b0;
      occ       <= OW'(VALID_AT_RESET);
    end else if (clear) begin
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      out_rpt   <= 1'b0;
      occ       <= '0;
    end else begin
      if (take_fifo) begin
        out_beat  <= fifo_dout[BEATW-1:0];
        out_last  <= fifo_dout[BEATW];
        out_valid <= 1'b1;
        out_rpt   <= 1'b0;
      end else if (take_commit) begin
        out_beat  <= commit_beat;
        out_last  <= beat_last;
        out_valid <= 1'b1;
        out_rpt   <= 1'b0;
      end else if (hs) begin
        out_last <= 1'b0;
        if (REPEATS != 0) begin
          out_rpt <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (accept && !dec)
        occ <= occ + OW'(1);
      else if (!accept && dec)
        occ <= occ - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_stb    <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      error_stb <= drop;
      if (drop) overflow_cnt <= sat_inc(overflow_cnt);
    end
  end

  generate
    if (MSB_ALIGN != 0) begin : g_msb
      assign o_tdata = out_beat[BEATW-1 -: WIDTH];
    end else begin : g_lsb
      assign o_tdata = out_beat[WIDTH-1:0];
    end
  endgenerate

  assign o_tlast  = out_last;
  assign o_tvalid = out_valid;
  assign occupied = occ;

endmodule

// File: tb/tb_axi_setting_reg_wide.sv
// Directed bench for axi_setting_reg_wide: one instance with tlast address,
// one with repeats and strobe-last, sharing the settings address/data bus.
module tb_axi_setting_reg_wide;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        stb_a, stb_b;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        rdy_a, rdy_b;

  logic [63:0] tdata_a, tdata_b;
  logic        tlast_a, tlast_b;
  logic        tvalid_a, tvalid_b;
  logic [2:0]  occ_a, occ_b;
  logic        err_a, err_b;
  logic [15:0] ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  axi_setting_reg_wide #(
    .NWORDS(2), .WIDTH(64), .FIFO_SIZE(2), .USE_ADDR_LAST(1), .ADDR_LAST(2)
  ) dut_a (
    .clk(clk), .reset(rst), .clear(clr), .set_stb(stb_a), .set_addr(addr),
    .set_data(data), .o_tdata(tdata_a), .o_tlast(tlast_a), .o_tvalid(tvalid_a),
    .o_tready(rdy_a), .occupied(occ_a), .error_stb(err_a), .overflow_cnt(ovf_a)
  );

  axi_setting_reg_wide #(
    .NWORDS(2), .WIDTH(64), .FIFO_SIZE(2), .REPEATS(1), .STROBE_LAST(1)
  ) dut_b (
    .clk(clk), .reset(rst), .clear(clr), .set_stb(stb_b), .set_addr(addr),
    .set_data(data), .o_tdata(tdata_b), .o_tlast(tlast_b), .o_tvalid(tvalid_b),
    .o_tready(rdy_b), .occupied(occ_b), .error_stb(err_b), .overflow_cnt(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit to_b, input logic [7:0] a, input logic [31:0] d);
    addr = a;
    data = d;
    if (to_b) stb_b = 1'b1;
    else      stb_a = 1'b1;
    tick();
    stb_a = 1'b0;
    stb_b = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
    addr = '0; data = '0; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_valid_a", 64'(tvalid_a), 64'd0);
    check("rst_tdata_a", tdata_a, 64'd0);
    check("rst_tlast_a", 64'(tlast_a), 64'd0);
    check("rst_occ_a", 64'(occ_a), 64'd0);
    check("rst_err_a", 64'(err_a), 64'd0);
    check("rst_ovf_a", 64'(ovf_a), 64'd0);
    check("rst_valid_b", 64'(tvalid_b), 64'd0);

    // Basic two-word beat
    rdy_a = 1'b1;
    wr(1'b0, 8'd0, 32'h1111_1111);
    check("t1_stage_novalid", 64'(tvalid_a), 64'd0);
    wr(1'b0, 8'd1, 32'h2222_2222);
    check("t1_valid", 64'(tvalid_a), 64'd1);
    check("t1_tdata", tdata_a, 64'h2222_2222_1111_1111);
    check("t1_tlast", 64'(tlast_a), 64'd0);
    check("t1_occ", 64'(occ_a), 64'd1);
    tick();
    check("t1_drain_valid", 64'(tvalid_a), 64'd0);
    check("t1_drain_occ", 64'(occ_a), 64'd0);

    // Overflow with a stalled sink
    rdy_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wr(1'b0, 8'd1, 32'(k));
      if (k <= 4) exp_q.push_back({32'(k), 32'h1111_1111});
      if (k == 4) check("t2_occ_full", 64'(occ_a), 64'd4);
      if (k >= 5) begin
        check("t2_err_pulse", 64'(err_a), 64'd1);
        check("t2_ovf", 64'(ovf_a), 64'(k - 4));
      end
    end
    check("t2_occ_after", 64'(occ_a), 64'd4);
    tick();
    check("t2_err_clear", 64'(err_a), 64'd0);
    rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", 64'(tvalid_a), 64'd1);
      check("t2_drain_data", tdata_a, exp_q.pop_front());
      tick();
    end
    check("t2_empty_valid", 64'(tvalid_a), 64'd0);
    check("t2_empty_occ", 64'(occ_a), 64'd0);

    // Full queue, handshake and commit in the same cycle
    rdy_a = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      wr(1'b0, 8'd1, 32'(k));
      exp_q.push_back({32'(k), 32'h1111_1111});
    end
    check("t5_occ_full", 64'(occ_a), 64'd4);
    check("t5_head", tdata_a, exp_q.pop_front());
    rdy_a = 1'b1;
    wr(1'b0, 8'd1, 32'd11);
    exp_q.push_back({32'd11, 32'h1111_1111});
    check("t5_no_err", 64'(err_a), 64'd0);
    check("t5_occ_cap", 64'(occ_a), 64'd4);
    check("t5_ovf_hold", 64'(ovf_a), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_data", tdata_a, exp_q.pop_front());
      tick();
    end
    check("t5_empty_valid", 64'(tvalid_a), 64'd0);

    // tlast via the extra commit address
    wr(1'b0, 8'd1, 32'h33);
    check("t3_word_valid", 64'(tvalid_a), 64'd1);
    check("t3_word_tlast", 64'(tlast_a), 64'd0);
    check("t3_word_data", tdata_a, 64'h0000_0033_1111_1111);
    wr(1'b0, 8'd2, 32'h44);
    check("t3_last_tlast", 64'(tlast_a), 64'd1);
    check("t3_last_data", tdata_a, 64'h0000_0044_1111_1111);
    tick();
    check("t3_last_drain", 64'(tvalid_a), 64'd0);

    // Strobe-last: every commit has tlast, output stable under stall
    wr(1'b1, 8'd1, 32'h55);
    check("t3b_valid", 64'(tvalid_b), 64'd1);
    check("t3b_tlast0", 64'(tlast_b), 64'd1);
    check("t3b_data0", tdata_b, 64'h0000_0055_0000_0000);
    wr(1'b1, 8'd1, 32'h66);
    check("t3b_occ2", 64'(occ_b), 64'd2);
    check("t3b_stable", tdata_b, 64'h0000_0055_0000_0000);
    rdy_b = 1'b1;
    tick();
    check("t3b_data1", tdata_b, 64'h0000_0066_0000_0000);
    check("t3b_tlast1", 64'(tlast_b), 64'd1);
    check("t3b_occ1", 64'(occ_b), 64'd1);
    tick();
    check("t3b_rpt_valid", 64'(tvalid_b), 64'd1);
    check("t3b_rpt_tlast", 64'(tlast_b), 64'd0);
    check("t3b_rpt_occ", 64'(occ_b), 64'd0);

    // Repeats: beat re-presented until replaced
    wr(1'b1, 8'd1, 32'hA5);
    check("t4_first_data", tdata_b, 64'h0000_00A5_0000_0000);
    check("t4_first_tlast", 64'(tlast_b), 64'd1);
    check("t4_first_occ", 64'(occ_b), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_rpt_valid", 64'(tvalid_b), 64'd1);
      check("t4_rpt_tlast", 64'(tlast_b), 64'd0);
      check("t4_rpt_data", tdata_b, 64'h0000_00A5_0000_0000);
      check("t4_rpt_occ", 64'(occ_b), 64'd0);
    end
    wr(1'b1, 8'd1, 32'h5A);
    check("t4_new_data", tdata_b, 64'h0000_005A_0000_0000);
    check("t4_new_tlast", 64'(tlast_b), 64'd1);
    check("t4_new_occ", 64'(occ_b), 64'd1);
    rdy_b = 1'b0;

    // Clear flush, then asynchronous reset mid-stream
    rdy_a = 1'b0;
    wr(1'b0, 8'd1, 32'h71);
    wr(1'b0, 8'd1, 32'h72);
    wr(1'b0, 8'd1, 32'h73);
    check("t6_occ3", 64'(occ_a), 64'd3);
    clr = 1'b1;
    wr(1'b0, 8'd1, 32'h74);
    clr = 1'b0;
    check("t6_clr_occ", 64'(occ_a), 64'd0);
    check("t6_clr_valid", 64'(tvalid_a), 64'd0);
    check("t6_clr_tlast", 64'(tlast_a), 64'd0);
    check("t6_clr_err", 64'(err_a), 64'd0);
    check("t6_clr_tdata", tdata_a, 64'h0000_0071_1111_1111);
    tick();
    check("t6_clr_discard", 64'(tvalid_a), 64'd0);

    wr(1'b0, 8'd1, 32'h81);
    check("t6_pre_rst_valid", 64'(tvalid_a), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("t6_arst_valid", 64'(tvalid_a), 64'd0);
    check("t6_arst_tdata", tdata_a, 64'd0);
    check("t6_arst_occ", 64'(occ_a), 64'd0);
    check("t6_arst_ovf", 64'(ovf_a), 64'd0);
    #1 rst = 1'b0;
    tick();
    rdy_a = 1'b1;
    wr(1'b0, 8'd1, 32'h91);
    check("t6_post_valid", 64'(tvalid_a), 64'd1);
    check("t6_post_data", tdata_a, 64'h0000_0091_0000_0000);
    check("t6_post_tlast", 64'(tlast_a), 64'd0);
    check("t6_post_occ", 64'(occ_a), 64'd1);
    tick();
    check("t6_post_drain", 64'(tvalid_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
